// File: rtl/can_pkg.sv
// Constants shared by the CAN receive CRC checker and the transmit CRC-15 generator.
package can_pkg;

    localparam int unsigned      CRC_W        = 15;
    localparam logic [CRC_W-1:0] CAN_CRC_POLY = 15'h4599;
    localparam int unsigned      STUFF_LIMIT  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COVER  = 2'd1,
        ST_CRC_RX = 2'd2,
        ST_DELIM  = 2'd3
    } crc_state_e;

endpackage

// File: rtl/can_crc_check_if.sv
// Bit-stream and verdict signals between the bit-timing unit, the CRC checker and the frame decoder.
interface can_crc_check_if #(
    parameter int unsigned LEN_W = 7,
    parameter int unsigned CRC_W = 15
);
    logic             bit_en;
    logic             rx_bit;
    logic             frame_start;
    logic [LEN_W-1:0] cov_len;
    logic             dbit_valid;
    logic             dbit;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic             stuff_err;
    logic             form_err;
    logic [CRC_W-1:0] crc_calc;

    modport master (
        output bit_en, rx_bit, frame_start, cov_len,
        input  dbit_valid, dbit, busy, done, crc_ok, crc_err, stuff_err, form_err, crc_calc
    );

    modport slave (
        input  bit_en, rx_bit, frame_start, cov_len,
        output dbit_valid, dbit, busy, done, crc_ok, crc_err, stuff_err, form_err, crc_calc
    );
endinterface

// File: rtl/can_destuff.sv
// Bit-destuffer: tracks the run of identical bits, flags stuff bits to drop and stuff violations.
module can_destuff
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic en_i,
    input  logic bit_i,
    output logic data_o,
    output logic stuff_err_o
);

    logic [2:0] run_q, run_d;
    logic       last_q, last_d;
    logic       at_limit;

    assign at_limit = (run_q == 3'(STUFF_LIMIT));

    always_comb begin
        run_d       = run_q;
        last_d      = last_q;
        data_o      = 1'b0;
        stuff_err_o = 1'b0;
        if (start_i) begin
            last_d = bit_i;
            run_d  = 3'd1;
        end else if (en_i) begin
            if (at_limit) begin
                // A valid stuff bit is dropped but still opens the next run.
                if (bit_i != last_q) begin
                    last_d = bit_i;
                    run_d  = 3'd1;
                end else begin
                    stuff_err_o = 1'b1;
                end
            end else begin
                data_o = 1'b1;
                if (bit_i == last_q) begin
                    run_d = run_q + 3'd1;
                end else begin
                    last_d = bit_i;
                    run_d  = 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_crc_check.sv
// Receive CRC-15 checker: destuffs the raw bus stream, accumulates the CRC and issues one verdict per frame.
module can_crc_check #(
    parameter int unsigned           CRC_W = can_pkg::CRC_W,
    parameter logic [CRC_W-1:0]      POLY  = can_pkg::CAN_CRC_POLY,
    parameter int unsigned           LEN_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    can_crc_check_if.slave  bus
);

    import can_pkg::*;

    crc_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] rxcrc_q, rxcrc_d;
    logic             dv_q, dv_d, dbit_q, dbit_d, busy_q, busy_d, done_q, done_d;
    logic             ok_q, ok_d, err_q, err_d, serr_q, serr_d, ferr_q, ferr_d;

    logic             start, ds_en, ds_data, ds_err;
    logic [LEN_W-1:0] eff_len;
    logic [CRC_W-1:0] crc_sof, crc_next;

    assign start   = bus.frame_start & bus.bit_en;
    assign eff_len = (bus.cov_len == '0) ? LEN_W'(1) : bus.cov_len;
    assign ds_en   = bus.bit_en & ~start & ((state_q == ST_COVER) | (state_q == ST_CRC_RX));

    // SOF is applied on top of the zero initial value in the same cycle.
    assign crc_sof  = bus.rx_bit ? POLY : '0;
    assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ ((bus.rx_bit ^ crc_q[CRC_W-1]) ? POLY : '0);

    can_destuff u_destuff (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .en_i        (ds_en),
        .bit_i       (bus.rx_bit),
        .data_o      (ds_data),
        .stuff_err_o (ds_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        crc_d   = crc_q;
        rxcrc_d = rxcrc_q;
        dv_d    = 1'b0;
        dbit_d  = dbit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        serr_d  = serr_q;
        ferr_d  = ferr_q;
        if (start) begin
            crc_d   = crc_sof;
            rxcrc_d = '0;
            dv_d    = 1'b1;
            dbit_d  = bus.rx_bit;
            busy_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            serr_d  = 1'b0;
            ferr_d  = 1'b0;
            len_d   = eff_len;
            if (eff_len == LEN_W'(1)) begin
                state_d = ST_CRC_RX;
                cnt_d   = '0;
            end else begin
                state_d = ST_COVER;
                cnt_d   = LEN_W'(1);
            end
        end else if (bus.bit_en) begin
            unique case (state_q)
                ST_COVER, ST_CRC_RX: begin
                    if (ds_err) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        serr_d  = 1'b1;
                    end else if (ds_data) begin
                        dv_d   = 1'b1;
                        dbit_d = bus.rx_bit;
                        if (state_q == ST_COVER) begin
                            crc_d = crc_next;
                            if (cnt_q + LEN_W'(1) == len_q) begin
                                state_d = ST_CRC_RX;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + LEN_W'(1);
                            end
                        end else begin
                            rxcrc_d = {rxcrc_q[CRC_W-2:0], bus.rx_bit};
                            if (cnt_q == LEN_W'(CRC_W - 1)) begin
                                state_d = ST_DELIM;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + LEN_W'(1);
                            end
                        end
                    end
                end
                ST_DELIM: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (!bus.rx_bit) begin
                        ferr_d = 1'b1;
                    end else if (rxcrc_q == crc_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            crc_q   <= '0;
            rxcrc_q <= '0;
            dv_q    <= 1'b0;
            dbit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            serr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            rxcrc_q <= rxcrc_d;
            dv_q    <= dv_d;
            dbit_q  <= dbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            serr_q  <= serr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.dbit_valid = dv_q;
    assign bus.dbit       = dbit_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.crc_ok     = ok_q;
    assign bus.crc_err    = err_q;
    assign bus.stuff_err  = serr_q;
    assign bus.form_err   = ferr_q;
    assign bus.crc_calc   = crc_q;

endmodule

// File: tb/tb_can_crc_check.sv
// Scoreboard bench for can_crc_check: directed raw bit streams with hand-computed destuffed bits and verdicts.
module tb_can_crc_check;

    typedef struct {
        logic [3:0]  flags;   // {crc_ok, crc_err, stuff_err, form_err}
        logic [14:0] crc;
        int          cnt;
    } verdict_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       last_be = -10;
    int       dcnt = 0;
    logic     dq[$];
    verdict_t vq[$];

    can_crc_check_if #(.LEN_W(7), .CRC_W(15)) bus ();

    can_crc_check #(.CRC_W(15), .POLY(15'h4599), .LEN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_verdict(input logic [3:0] flags, input logic [14:0] crc, input int cnt);
        verdict_t v;
        v.flags = flags;
        v.crc   = crc;
        v.cnt   = cnt;
        vq.push_back(v);
    endtask

    // Drive one raw bit for one cycle, then idle for gap cycles (gap<0 picks a random 0..3).
    task automatic drive(input logic b, input logic fs, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        bus.bit_en      = 1'b1;
        bus.rx_bit      = b;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.bit_en      = 1'b0;
        bus.frame_start = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // '0'/'1' data bits, 'S' stuff one, 'x' offending zero, 'D'/'d' delimiter 1/0; first bit is SOF.
    task automatic send(input string s, input int gap);
        bit   first;
        byte  c;
        logic b;
        bit   data;
        first = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == " ") continue;
            case (c)
                "0":     begin b = 1'b0; data = 1'b1; end
                "1":     begin b = 1'b1; data = 1'b1; end
                "S":     begin b = 1'b1; data = 1'b0; end
                "D":     begin b = 1'b1; data = 1'b0; end
                default: begin b = 1'b0; data = 1'b0; end
            endcase
            if (data) dq.push_back(b);
            drive(b, first, gap);
            first = 1'b0;
        end
    endtask

    function automatic logic [22:0] out_vec();
        return {bus.dbit_valid, bus.dbit, bus.busy, bus.done, bus.crc_ok,
                bus.crc_err, bus.stuff_err, bus.form_err, bus.crc_calc};
    endfunction

    always @(negedge clk) begin
        verdict_t v;
        logic     e;
        cyc++;
        if (bus.dbit_valid) begin
            if (dq.size() == 0) begin
                chk("unexpected_dbit", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                chk("dbit", {31'd0, bus.dbit}, {31'd0, e});
            end
            dcnt++;
        end
        if (bus.done) begin
            if (vq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                v = vq.pop_front();
                chk("verdict_flags", {28'd0, bus.crc_ok, bus.crc_err, bus.stuff_err, bus.form_err},
                    {28'd0, v.flags});
                chk("crc_calc", {17'd0, bus.crc_calc}, {17'd0, v.crc});
                chk("dbit_count", dcnt, v.cnt);
                chk("done_latency", cyc, last_be + 1);
                chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
        end
        if (rst || (bus.bit_en && bus.frame_start)) dcnt = 0;
        if (bus.bit_en) last_be = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.bit_en      = 1'b0;
        bus.rx_bit      = 1'b0;
        bus.frame_start = 1'b0;
        bus.cov_len     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {9'd0, out_vec()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stuffed all-zero frame, back-to-back bits
        bus.cov_len = 7'd1;
        expect_verdict(4'b1000, 15'h0000, 16);
        send("0 0000S 00000S 00000S 0 D", 0);

        // Single covered 1 gives CRC 0x4599
        expect_verdict(4'b1000, 15'h4599, 16);
        send("1 100010110011001 D", 1);
        repeat (3) @(posedge clk);
        #1;
        chk("flags_held", {31'd0, bus.crc_ok}, 32'd1);

        // Last CRC bit flipped; cov_len 0 behaves as 1
        bus.cov_len = 7'd0;
        expect_verdict(4'b0100, 15'h4599, 16);
        send("1 100010110011000 D", 2);

        // Two covered bits 1,0 give 0x4EAB
        bus.cov_len = 7'd2;
        expect_verdict(4'b1000, 15'h4EAB, 17);
        send("10 100111010101011 D", 0);

        // Six covered zeros: stuff error on the sixth
        bus.cov_len = 7'd8;
        expect_verdict(4'b0010, 15'h0000, 5);
        send("00000x", 0);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_after_stuff_err", {31'd0, bus.busy}, 32'd0);
        drive(1'b0, 1'b0, 0);
        chk("idle_ignores_bit", {31'd0, bus.dbit_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Delimiter dominant
        bus.cov_len = 7'd1;
        expect_verdict(4'b0001, 15'h4599, 16);
        send("1 100010110011001 d", 0);

        // Reset mid-frame, then a full frame
        send("1 10", 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mid_frame", {9'd0, out_vec()}, 32'd0);
        expect_verdict(4'b1000, 15'h4599, 16);
        send("1 100010110011001 D", 0);

        // frame_start mid-frame aborts and restarts
        send("1 10", 0);
        expect_verdict(4'b1000, 15'h4599, 16);
        send("1 100010110011001 D", 0);

        // Stuffed zero frame again with random gaps between bits
        expect_verdict(4'b1000, 15'h0000, 16);
        send("0 0000S 00000S 00000S 0 D", -1);

        repeat (5) @(posedge clk);
        #1;
        chk("dbit_queue_empty", dq.size(), 32'd0);
        chk("verdict_queue_empty", vq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_crc_check.md
# can_crc_check

Receive-side CRC checker for the CAN controller, the counterpart of the transmit-path CRC-15 generator. It takes raw sampled bus bits from the bit-timing unit and removes stuff bits. It accumulates a bit-serial CRC-15 over the covered field (SOF through end of data) and compares it with the received 15-bit CRC sequence. It also checks the CRC delimiter and reports a single verdict per frame to the receive frame decoder.

## Interface
Parameters:
- CRC_W, 15, CRC width.
- POLY, 15'h4599, CAN polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, with the x^15 term implicit.
- LEN_W, 7, width of the covered-bit count; 103 bits max for an extended frame with 8 data bytes.

Ports:
- clk  in  1  single clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_en  in  1  one-cycle strobe; rx_bit is valid in this cycle.
- rx_bit  in  1  sampled bus bit; 0 is dominant.
- frame_start  in  1  asserted together with bit_en on the SOF bit.
- cov_len  in  LEN_W  number of destuffed covered bits, including SOF; sampled when frame_start is high.
- dbit_valid  out  1  one-cycle strobe per destuffed bit (covered and CRC bits), forwarded to the frame decoder.
- dbit  out  1  destuffed bit value.
- busy  out  1  high from frame_start until the verdict.
- done  out  1  one-cycle verdict pulse.
- crc_ok, crc_err, stuff_err, form_err  out  1 each  verdict flags; valid with done and held until the next frame_start or rst.
- crc_calc  out  CRC_W  the calculated CRC register.

## Operation
- States:
  - IDLE to COVER on frame_start & bit_en.
  - COVER to CRC_RX after cov_len destuffed bits.
  - CRC_RX to DELIM after 15 destuffed bits.
  - DELIM to IDLE on the next bit_en.
  - Any state to IDLE on a stuff error.
- Destuffing, COVER and CRC_RX only:
  - Track the last bit value and a run counter from 1 to 5. SOF starts the run at 1.
  - After a run of 5 identical bits, the next raw bit is a stuff bit. If it is the complement, drop it; it becomes the first bit of a new run (run=1). If it equals the run value, raise stuff_err.
  - Stuff bits produce no dbit_valid, are not fed to the CRC, and are not counted.
  - The DELIM bit is never destuffed.
- CRC update per covered destuffed bit b: n = b ^ crc[14]; crc = {crc[13:0],1'b0} ^ (n ? POLY : 0). Initial value is 0, loaded on frame_start before the SOF bit is applied.
- CRC_RX: received bits are shifted MSB-first into a 15-bit rx_crc. crc_calc is frozen.
- DELIM:
  - rx_bit=0 gives form_err.
  - Otherwise the comparison decides: rx_crc==crc_calc gives crc_ok, anything else gives crc_err.
  - form_err takes priority; crc_ok and crc_err are both 0 when form_err is set.
- Exactly one verdict flag is 1 with each done.
- frame_start while busy aborts the current frame with no done, clears the flags, and restarts from the SOF bit.
- cov_len=0 is treated as 1.
- bit_en low: state holds; gaps of any length between bits are legal.

## Timing
- All outputs are registered.
- dbit_valid/dbit appear 1 cycle after the accepted bit_en.
- done and flags appear 1 cycle after the DELIM bit_en, or 1 cycle after the offending stuff bit.
- busy falls in the same cycle done rises.
- Reset values: every output 0; crc_calc 0; state IDLE; run counter 0.
- rst during a frame: immediate return to IDLE with no done pulse.
- Minimum spacing between bit_en pulses is 1 cycle; back-to-back bit_en every cycle must work.

## Structure
- Shared package can_pkg holds CRC_W, CAN_CRC_POLY (15'h4599), the stuff limit (5) and the state enum; the transmit CRC generator uses the same constants.
- One sub-module, can_destuff, handles the run counter, stuff-bit drop and stuff_err, with an enable input. The top module holds the FSM, bit counter, CRC register, rx_crc shift register and comparator.

## Test plan
- Stuffed zero frame: cov_len=1. Raw stream 0, 0000, 1, 00000, 1, 00000, 1, 0, then delimiter 1 (the 1s after each run of five zeros are stuff bits). Required: three stuff bits dropped, 16 dbit_valid pulses, crc_calc=0, done with crc_ok=1.
- Non-zero CRC: cov_len=1, covered bit 1, then CRC 100010110011001, then delimiter 1. Required: crc_calc=15'h4599, crc_ok=1.
- Same frame with the last CRC bit flipped. Required: crc_err=1, crc_ok=0.
- Covered stream of six 0s with cov_len=8. Required: stuff_err=1 with done 1 cycle after the 6th bit, busy=0, and the FSM returns to IDLE.
- Second scenario with delimiter 0. Required: form_err=1, crc_ok=0, crc_err=0.
- rst asserted after 3 bits, then a full second-scenario frame. Required: no done for the aborted frame and crc_ok for the second. Repeat with frame_start instead of rst, with the same required response.
